// File: rtl/mstage_lsu.sv
// Memory-stage load/store unit: takes one X->M op at a time, issues at most one
// word-aligned memory request for it, and hands the extended result to the W stage.
module mstage_lsu #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter bit CHK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              mvalidM,
    input  logic              mwenM,
    input  logic [7:0]        mwmaskM,
    input  logic [2:0]        mrtypeM,
    input  logic [ADDR_W-1:0] ALU_resultM,
    input  logic [DATA_W-1:0] src2M,
    input  logic [4:0]        rdM,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp_err,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] resultW,
    output logic [4:0]        rdW,
    output logic              errW
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [3:0]        mask_q;
    logic [2:0]        rtype_q;
    logic [DATA_W-1:0] src2_q;
    logic              misalign;
    logic              accept;
    logic              unused_mask_hi;

    // Byte lanes above the 32-bit word are never addressed.
    assign unused_mask_hi = ^mwmaskM[7:4];

    // Shift the addressed byte/half down to lane 0, then sign- or zero-extend.
    function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] rdata,
                                                   input logic [1:0]        off,
                                                   input logic [2:0]        rtype);
        logic [DATA_W-1:0]        sh;
        logic signed [7:0]        b8;
        logic signed [15:0]       h16;
        logic signed [DATA_W-1:0] ext;
        sh  = rdata >> {off, 3'b000};
        b8  = sh[7:0];
        h16 = sh[15:0];
        case (rtype)
            3'd0:    ext = DATA_W'(b8);
            3'd1:    ext = DATA_W'(h16);
            3'd4:    ext = $signed(DATA_W'(sh[7:0]));
            3'd5:    ext = $signed(DATA_W'(sh[15:0]));
            default: ext = $signed(sh);
        endcase
        return ext;
    endfunction

    always_comb begin
        misalign = 1'b0;
        if (CHK_ALIGN && mvalidM) begin
            if (mwenM) begin
                misalign = (mwmaskM[3:0] == 4'hF) && (ALU_resultM[1:0] != 2'b00);
            end else begin
                case (mrtypeM)
                    3'd0, 3'd4: misalign = 1'b0;
                    3'd1, 3'd5: misalign = ALU_resultM[0];
                    default:    misalign = (ALU_resultM[1:0] != 2'b00);
                endcase
            end
        end
    end

    assign accept = (state == IDLE) && s_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        s_ready       = 1'b0;
        mem_req_valid = 1'b0;
        m_valid       = 1'b0;
        case (state)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    state_n = (!mvalidM || misalign) ? DONE : REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_n = RESP;
            end
            RESP: begin
                if (mem_resp_valid) state_n = DONE;
            end
            DONE: begin
                m_valid = 1'b1;
                if (m_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Latched op: only meaningful while an op is in flight, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= ALU_resultM;
            wen_q   <= mwenM;
            mask_q  <= mwmaskM[3:0];
            rtype_q <= mrtypeM;
            src2_q  <= src2M;
        end
    end

    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wen   = wen_q;
    assign mem_wdata = src2_q << {addr_q[1:0], 3'b000};
    assign mem_wmask = mask_q << addr_q[1:0];

    // W-stage result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resultW <= '0;
            rdW     <= '0;
            errW    <= 1'b0;
        end else if (accept) begin
            rdW <= rdM;
            if (!mvalidM) begin
                resultW <= DATA_W'(ALU_resultM);
                errW    <= 1'b0;
            end else if (misalign) begin
                resultW <= '0;
                errW    <= 1'b1;
            end
        end else if (state == RESP && mem_resp_valid) begin
            errW    <= mem_resp_err;
            resultW <= wen_q ? DATA_W'(addr_q) : load_ext(mem_rdata, addr_q[1:0], rtype_q);
        end
    end

endmodule
